alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Parametrised, handshaked successor to the 32-bit integer ALU. It performs the full RV32I ALU op set in one cycle with a registered output. It also performs the RV32M multiply/divide/remainder ops iteratively, with a multi-cycle FSM. It sits in the EX stage and can stall the pipeline through valid/ready handshakes on the input and output sides.

Parameters:
XLEN, 32, operand/result width; must be a power of 2 and at least 8.
SHW, $clog2(XLEN), number of shift-amount bits taken from DATA2.

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  synchronous, active-low reset
IN_VALID  in  1  operation request
IN_READY  out  1  block can accept a request this cycle
OP  in  5  operation select (encoding below)
DATA1  in  XLEN  operand A (rs1)
DATA2  in  XLEN  operand B (rs2/imm)
OUT_VALID  out  1  RESULT and flags are valid
OUT_READY  in  1  consumer takes the result
RESULT  out  XLEN  registered result
ZERO  out  1  RESULT == 0
SIGN  out  1  RESULT[XLEN-1]
SLTU  out  1  RESULT[0]

Behaviour:
- OP encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU
  - 18-31 reserved: result 0, handled as a basic op.
- Shifts use DATA2[SHW-1:0] only. SRA sign-fills.
- SLT/SLTU return 1 or 0 in bit 0.
- Reset (RESET_N=0 at a clock edge): state=IDLE, OUT_VALID=0, RESULT=0, all iteration registers cleared. Flags derive from RESULT, so ZERO=1, SIGN=0, SLTU=0. Reset mid-operation aborts it; no result is produced.
- IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY). It is combinational and does not depend on IN_VALID.
- Accept: IN_VALID && IN_READY at a rising edge. DATA1, DATA2 and OP are captured on that edge.
- OUT_VALID && OUT_READY at an edge clears OUT_VALID unless a new result is loaded on the same edge.
- FSM states: IDLE, CALC, DONE.
  - IDLE: accepting a basic op loads RESULT and sets OUT_VALID on the same edge, so latency is 1. Back-to-back issue gives 1 op/cycle while OUT_READY=1.
  - IDLE: accepting a MUL*/DIV*/REM* op moves to CALC. Operands are converted to magnitudes per signedness, the result sign is recorded, and cnt=0.
  - CALC: one iteration per cycle, shift-add multiply or restoring divide, 1 bit per cycle. After XLEN iterations, go to DONE.
  - DONE: sign-correct, select the hi/lo product or the quotient/remainder, load RESULT, set OUT_VALID, return to IDLE.
  - Result latency for iterative ops is XLEN+2 edges after accept (34 for XLEN=32). IN_READY=0 throughout CALC and DONE.
- DONE with OUT_VALID=1 and OUT_READY=0: hold in DONE until the output slot frees. RESULT must never be overwritten while OUT_VALID && !OUT_READY.
- Multiply: the full 2·XLEN-bit product is formed.
  - MUL returns the low XLEN bits.
  - MULH returns the high half, signed×signed.
  - MULHSU returns the high half, signed×unsigned.
  - MULHU returns the high half, unsigned×unsigned.
- Divide follows RISC-V rules and needs no trap:
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give DATA1. The full iteration count is still used, so latency is constant.
  - Signed overflow (DATA1 = -2^(XLEN-1), DATA2 = -1): DIV gives DATA1, REM gives 0.
  - Remainder takes the sign of the dividend; quotient rounds toward zero.
- While OUT_VALID=1, RESULT and the flags are stable.

Decomposition:
- Package alu_pkg:
  - 5-bit op enum: ALU_ADD … ALU_REMU.
  - State enum: IDLE/CALC/DONE.
  - Helper function is_iterative(op).
- One sub-module, muldiv_iter: the CALC datapath.
  - Holds the accumulator, the shifting operand, the counter and the sign-fix logic.
  - Interface: start, op, a, b in; done, result out.
- Top-level alu_muldiv_seq contains the handshake, the FSM, the basic-op combinational unit and the output register.

Test Plan:
- Reset: assert RESET_N=0 for 2 cycles during CALC of a DIV, then release. Expect OUT_VALID=0, RESULT=0, ZERO=1, IN_READY=1, and no stale result afterwards.
- Basic stream, XLEN=32, OUT_READY=1: ADD 5+7, then SRA 0x80000000 by 4, then SLTU 1<2 on consecutive cycles. Expect 12, 0xF8000000 and 1 on the next three cycles, one per cycle.
- Multiply: MULH 0xFFFFFFFF × 0xFFFFFFFF gives 0. MULHU of the same gives 0xFFFFFFFE. MUL 0x10000 × 0x10000 gives 0. OUT_VALID rises exactly 34 cycles after accept.
- Divide corner cases:
  - DIV 7 ÷ 0 gives 0xFFFFFFFF; REMU 7 ÷ 0 gives 7.
  - DIV 0x80000000 ÷ -1 gives 0x80000000; REM of the same gives 0.
  - DIV -7 ÷ 2 gives -3; REM -7 ÷ 2 gives -1.
- Backpressure: hold OUT_READY=0 after a MUL completes. RESULT stays stable, IN_READY=0, and a new request is not accepted. Raising OUT_READY lets the next op be accepted on the same edge.
- Parameter sweep: rerun the divide/multiply checks with XLEN=8 (e.g. DIVU 200 ÷ 7 gives 28, REMU gives 4). Latency must be 10 cycles.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared op encodings, FSM state codes and helpers for the EX-stage ALU with
// iterative multiply/divide.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic is_iterative(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the EX-stage issue logic and the ALU.
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            IN_VALID;
    logic            IN_READY;
    logic [4:0]      OP;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [XLEN-1:0] RESULT;
    logic            ZERO;
    logic            SIGN;
    logic            SLTU;

    modport master (
        output IN_VALID, OP, DATA1, DATA2, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT, ZERO, SIGN, SLTU
    );

    modport slave (
        input  IN_VALID, OP, DATA1, DATA2, OUT_READY,
        output IN_READY, OUT_VALID, RESULT, ZERO, SIGN, SLTU
    );
endinterface

// File: rtl/alu_muldiv_seq_muldiv_iter.sv
// Bit-serial multiply (shift-add) and restoring divide on operand magnitudes,
// with sign correction and hi/lo or quotient/remainder selection at the end.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(XLEN);

    logic            r_busy;
    logic            r_is_div;
    logic            r_neg;
    logic            r_neg_rem;
    logic [4:0]      r_op;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [CW-1:0]   r_cnt;

    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_is_div;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    assign w_a_neg = i_a[XLEN-1] && ((i_op == ALU_MULH) || (i_op == ALU_MULHSU) ||
                                     (i_op == ALU_DIV)  || (i_op == ALU_REM));
    assign w_b_neg = i_b[XLEN-1] && ((i_op == ALU_MULH) || (i_op == ALU_DIV) ||
                                     (i_op == ALU_REM));
    assign w_is_div = (i_op >= ALU_DIV);
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // Multiply: r_lo holds the multiplier and collects low product bits.
    // Divide: r_lo holds the dividend and collects quotient bits, r_hi the partial remainder.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    assign o_done = r_busy && (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy    <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg     <= 1'b0;
            r_neg_rem <= 1'b0;
            r_op      <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
        end else if (i_start) begin
            r_busy    <= 1'b1;
            r_is_div  <= w_is_div;
            // A zero divisor must yield an all-ones quotient, so no negation then.
            r_neg     <= w_is_div ? ((w_a_neg ^ w_b_neg) && (i_b != '0)) : (w_a_neg ^ w_b_neg);
            r_neg_rem <= w_a_neg;
            r_op      <= i_op;
            r_b       <= w_b_mag;
            r_hi      <= '0;
            r_lo      <= w_a_mag;
            r_cnt     <= '0;
        end else if (r_busy) begin
            if (r_cnt == CNT_MAX) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (r_is_div) begin
                    if (!w_diff[XLEN]) begin
                        r_hi <= w_diff[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b1};
                    end else begin
                        r_hi <= w_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    r_hi <= w_sum[XLEN:1];
                    r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                end
            end
        end
    end

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quot     = r_neg ? -r_lo : r_lo;
    assign w_rem      = r_neg_rem ? -r_hi : r_hi;

    always_comb begin
        o_result = '0;
        case (r_op)
            ALU_MUL:                          o_result = w_prod_fix[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  o_result = w_prod_fix[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                o_result = w_quot;
            ALU_REM, ALU_REMU:                o_result = w_rem;
            default:                          o_result = '0;
        endcase
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU: single-cycle RV32I ops, iterative RV32M ops, valid/ready on both sides.
//   state   | meaning
//   IDLE    | accepting requests; basic ops complete on the accept edge
//   CALC    | muldiv_iter running one bit per cycle
//   DONE    | waiting for a free output slot to publish the mul/div result
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    alu_muldiv_seq_if.slave  bus
);
    state_t          r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;

    logic            w_slot_free;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_iter_op;
    logic            w_iter_start;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;
    logic [XLEN-1:0] w_basic;
    logic [SHW-1:0]  w_shamt;

    assign w_slot_free  = !r_out_valid || bus.OUT_READY;
    assign w_in_ready   = (r_state == ST_IDLE) && w_slot_free;
    assign w_accept     = bus.IN_VALID && w_in_ready;
    assign w_iter_op    = is_iterative(bus.OP);
    assign w_iter_start = w_accept && w_iter_op;
    assign w_shamt      = bus.DATA2[SHW-1:0];

    always_comb begin
        w_basic = '0;
        case (bus.OP)
            ALU_ADD:  w_basic = bus.DATA1 + bus.DATA2;
            ALU_SUB:  w_basic = bus.DATA1 - bus.DATA2;
            ALU_SLL:  w_basic = bus.DATA1 << w_shamt;
            ALU_SLT:  w_basic = {{(XLEN-1){1'b0}}, $signed(bus.DATA1) < $signed(bus.DATA2)};
            ALU_SLTU: w_basic = {{(XLEN-1){1'b0}}, bus.DATA1 < bus.DATA2};
            ALU_XOR:  w_basic = bus.DATA1 ^ bus.DATA2;
            ALU_SRL:  w_basic = bus.DATA1 >> w_shamt;
            ALU_SRA:  w_basic = $unsigned($signed(bus.DATA1) >>> w_shamt);
            ALU_OR:   w_basic = bus.DATA1 | bus.DATA2;
            ALU_AND:  w_basic = bus.DATA1 & bus.DATA2;
            default:  w_basic = '0;
        endcase
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv_iter (
        .i_clk    (CLK),
        .i_rst_n  (RESET_N),
        .i_start  (w_iter_start),
        .i_op     (bus.OP),
        .i_a      (bus.DATA1),
        .i_b      (bus.DATA2),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            if (r_out_valid && bus.OUT_READY) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_iter_op) begin
                            r_state <= ST_CALC;
                        end else begin
                            r_result    <= w_basic;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (w_md_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_slot_free) begin
                        r_result    <= w_md_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.RESULT    = r_result;
    assign bus.ZERO      = (r_result == '0);
    assign bus.SIGN      = r_result[XLEN-1];
    assign bus.SLTU      = r_result[0];
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq at XLEN=32 and XLEN=8 with hand-computed expectations.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    alu_muldiv_seq_if #(.XLEN(32)) v32 ();
    alu_muldiv_seq_if #(.XLEN(8))  v8 ();

    alu_muldiv_seq #(.XLEN(32)) u32 (.CLK(CLK), .RESET_N(RESET_N), .bus(v32));
    alu_muldiv_seq #(.XLEN(8))  u8  (.CLK(CLK), .RESET_N(RESET_N), .bus(v8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic iter32(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int lat;
        @(negedge CLK);
        v32.OP = op; v32.DATA1 = a; v32.DATA2 = b; v32.IN_VALID = 1'b1;
        check({tag, "_rdy"}, v32.IN_READY, 1);
        @(posedge CLK); #1;
        v32.IN_VALID = 1'b0;
        lat = 0;
        while (v32.OUT_VALID !== 1'b1 && lat < 100) begin
            if (lat == 3) check({tag, "_busy"}, v32.IN_READY, 0);
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 34);
        check({tag, "_res"}, v32.RESULT, exp);
    endtask

    task automatic iter8(input string tag, input logic [4:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        int lat;
        @(negedge CLK);
        v8.OP = op; v8.DATA1 = a; v8.DATA2 = b; v8.IN_VALID = 1'b1;
        @(posedge CLK); #1;
        v8.IN_VALID = 1'b0;
        lat = 0;
        while (v8.OUT_VALID !== 1'b1 && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 10);
        check({tag, "_res"}, {24'h0, v8.RESULT}, {24'h0, exp});
    endtask

    initial begin
        logic stale;
        RESET_N = 1'b0;
        v32.IN_VALID = 1'b0; v32.OUT_READY = 1'b1; v32.OP = '0; v32.DATA1 = '0; v32.DATA2 = '0;
        v8.IN_VALID  = 1'b0; v8.OUT_READY  = 1'b1; v8.OP  = '0; v8.DATA1  = '0; v8.DATA2  = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ov", v32.OUT_VALID, 0);
        check("rst_res", v32.RESULT, 0);
        check("rst_zero", v32.ZERO, 1);
        check("rst_sign", v32.SIGN, 0);
        check("rst_sltu", v32.SLTU, 0);
        check("rst_rdy", v32.IN_READY, 1);
        check("rst8_res", {24'h0, v8.RESULT}, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // back-to-back basic ops, one result per cycle
        @(negedge CLK);
        v32.OP = ALU_ADD; v32.DATA1 = 32'd5; v32.DATA2 = 32'd7; v32.IN_VALID = 1'b1;
        @(posedge CLK); #1;
        check("add_ov", v32.OUT_VALID, 1);
        check("add", v32.RESULT, 32'd12);
        v32.OP = ALU_SRA; v32.DATA1 = 32'h8000_0000; v32.DATA2 = 32'd4;
        @(posedge CLK); #1;
        check("sra", v32.RESULT, 32'hF800_0000);
        check("sra_sign", v32.SIGN, 1);
        check("sra_rdy", v32.IN_READY, 1);
        v32.OP = ALU_SLTU; v32.DATA1 = 32'd1; v32.DATA2 = 32'd2;
        @(posedge CLK); #1;
        check("sltu", v32.RESULT, 32'd1);
        check("sltu_flag", v32.SLTU, 1);
        v32.OP = ALU_SUB; v32.DATA1 = 32'd3; v32.DATA2 = 32'd5;
        @(posedge CLK); #1;
        check("sub", v32.RESULT, 32'hFFFF_FFFE);
        v32.OP = ALU_SLL; v32.DATA1 = 32'd1; v32.DATA2 = 32'd33;
        @(posedge CLK); #1;
        check("sll_mask", v32.RESULT, 32'd2);
        v32.OP = ALU_SLT; v32.DATA1 = 32'hFFFF_FFFF; v32.DATA2 = 32'd1;
        @(posedge CLK); #1;
        check("slt", v32.RESULT, 32'd1);
        v32.OP = 5'd20; v32.DATA1 = 32'd5; v32.DATA2 = 32'd5;
        @(posedge CLK); #1;
        check("rsvd", v32.RESULT, 32'd0);
        check("rsvd_zero", v32.ZERO, 1);
        v32.IN_VALID = 1'b0;

        // multiply
        iter32("mulh",   ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        iter32("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        iter32("mul",    ALU_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        iter32("mul76",  ALU_MUL,    32'd7,         32'd6,         32'd42);
        iter32("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);

        // divide corners
        iter32("div0",   ALU_DIV,  32'd7,         32'd0,         32'hFFFF_FFFF);
        iter32("remu0",  ALU_REMU, 32'd7,         32'd0,         32'd7);
        iter32("divov",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        iter32("remov",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        iter32("divneg", ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        iter32("remneg", ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        iter32("remdvn", ALU_REM,  32'd7,         32'hFFFF_FFFE, 32'd1);
        iter32("divu",   ALU_DIVU, 32'd100,       32'd7,         32'd14);

        // backpressure
        @(posedge CLK); #1;
        v32.OUT_READY = 1'b0;
        iter32("bp_mul", ALU_MUL, 32'd3, 32'd4, 32'd12);
        @(negedge CLK);
        v32.OP = ALU_ADD; v32.DATA1 = 32'd1; v32.DATA2 = 32'd1; v32.IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("bp_hold", v32.RESULT, 32'd12);
        end
        check("bp_ov", v32.OUT_VALID, 1);
        check("bp_rdy", v32.IN_READY, 0);
        @(negedge CLK);
        v32.OUT_READY = 1'b1;
        #1;
        check("bp_rdy_up", v32.IN_READY, 1);
        @(posedge CLK); #1;
        check("bp_next", v32.RESULT, 32'd2);
        check("bp_next_ov", v32.OUT_VALID, 1);
        v32.IN_VALID = 1'b0;

        // XLEN=8
        iter8("divu8",  ALU_DIVU,  8'd200, 8'd7,  8'd28);
        iter8("remu8",  ALU_REMU,  8'd200, 8'd7,  8'd4);
        iter8("mulhu8", ALU_MULHU, 8'hFF,  8'hFF, 8'hFE);
        iter8("mul8",   ALU_MUL,   8'h10,  8'h10, 8'h00);
        iter8("divov8", ALU_DIV,   8'h80,  8'hFF, 8'h80);
        iter8("rem8",   ALU_REM,   8'hF9,  8'd2,  8'hFF);
        iter8("div08",  ALU_DIVU,  8'd9,   8'd0,  8'hFF);

        // reset in the middle of a divide
        @(negedge CLK);
        v32.OP = ALU_DIV; v32.DATA1 = 32'd100; v32.DATA2 = 32'd3; v32.IN_VALID = 1'b1;
        @(posedge CLK); #1;
        v32.IN_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("mrst_ov", v32.OUT_VALID, 0);
        check("mrst_res", v32.RESULT, 0);
        check("mrst_zero", v32.ZERO, 1);
        check("mrst_rdy", v32.IN_READY, 1);
        @(negedge CLK);
        RESET_N = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (v32.OUT_VALID !== 1'b0) stale = 1'b1;
        end
        check("mrst_stale", stale, 0);
        @(negedge CLK);
        v32.OP = ALU_XOR; v32.DATA1 = 32'hF0F0_0000; v32.DATA2 = 32'h0F0F_00FF; v32.IN_VALID = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_xor", v32.RESULT, 32'hFFFF_00FF);
        v32.IN_VALID = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
